// File: rtl/pes_univ_shift.sv
// pes_univ_shift
// ----------------------------------------------------------------------------
// Universal shift register: DEPTH stages of WIDTH-bit lanes with hold, right
// shift, left shift and parallel load. Every stage is exposed on a flat
// parallel bus, so the same block serves SISO, SIPO, PISO and PIPO roles.
// A shared shift counter raises a one-cycle frame_done pulse whenever DEPTH
// shifts have completed, so serial-to-parallel consumers can capture a full
// frame without keeping their own count.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears all state)
//   en           operation enable; low behaves exactly like hold
//   mode         00 hold, 01 shift right, 10 shift left, 11 parallel load
//   serial_in    right-shift input, enters stage 0
//   serial_in_l  left-shift input, enters stage DEPTH-1
//   par_in       load data, stage i = par_in[i*WIDTH +: WIDTH]
//   serial_out   stage DEPTH-1
//   serial_out_l stage 0
//   par_out      all stages, stage i at [i*WIDTH +: WIDTH]
//   shift_cnt    shifts completed in the current frame, 0..DEPTH-1
//   frame_done   registered pulse on the shift that completes a frame
// ----------------------------------------------------------------------------
module pes_univ_shift #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       serial_in,
  input  logic [WIDTH-1:0]       serial_in_l,
  input  logic [WIDTH*DEPTH-1:0] par_in,
  output logic [WIDTH-1:0]       serial_out,
  output logic [WIDTH-1:0]       serial_out_l,
  output logic [WIDTH*DEPTH-1:0] par_out,
  output logic [CW-1:0]          shift_cnt,
  output logic                   frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Last count value of a frame; the shift taken from here wraps to 0 and
  // fires frame_done, so the counter never reaches DEPTH.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  // Packed so that stage i occupies bits [i*WIDTH +: WIDTH] of the flat bus.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        shift_en;

  // Next-state logic. Left and right shifts both advance the same counter,
  // so frames made of mixed directions still complete after DEPTH shifts.
  // A load restarts the frame, which also swallows a pulse due on that edge.
  always_comb begin
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_en = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: begin
        end
        MODE_RIGHT: begin
          stage_d[0] = serial_in;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
          shift_en = 1'b1;
        end
        MODE_LEFT: begin
          stage_d[DEPTH-1] = serial_in_l;
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
          shift_en = 1'b1;
        end
        MODE_LOAD: begin
          stage_d = par_in;
          cnt_d   = '0;
        end
      endcase
    end

    if (shift_en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Every output is a straight register tap.
  assign par_out      = stage_q;
  assign serial_out   = stage_q[DEPTH-1];
  assign serial_out_l = stage_q[0];
  assign shift_cnt    = cnt_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_pes_univ_shift.sv
// tb_pes_univ_shift
// ----------------------------------------------------------------------------
// Bench for pes_univ_shift. Two instances: an 8-stage single-bit register and
// a 3-stage 4-bit-lane register. Operations are listed in a vector table with
// the values the spec dictates after each edge; expected records go onto a
// scoreboard queue as each operation is driven and are popped and compared
// once the edge has happened. A per-vector flag fires an asynchronous reset
// between edges to check the immediate clear.
// ----------------------------------------------------------------------------
module tb_pes_univ_shift;

  logic        clk;
  logic        reset;

  logic        en8, en3;
  logic [1:0]  mode8, mode3;
  logic        sin8, sinl8;
  logic [3:0]  sin3, sinl3;
  logic [7:0]  pin8;
  logic [11:0] pin3;
  logic        so8, sol8;
  logic [3:0]  so3, sol3;
  logic [7:0]  pout8;
  logic [11:0] pout3;
  logic [2:0]  cnt8;
  logic [1:0]  cnt3;
  logic        done8, done3;

  pes_univ_shift #(.WIDTH(1), .DEPTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .en           (en8),
    .mode         (mode8),
    .serial_in    (sin8),
    .serial_in_l  (sinl8),
    .par_in       (pin8),
    .serial_out   (so8),
    .serial_out_l (sol8),
    .par_out      (pout8),
    .shift_cnt    (cnt8),
    .frame_done   (done8)
  );

  pes_univ_shift #(.WIDTH(4), .DEPTH(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .en           (en3),
    .mode         (mode3),
    .serial_in    (sin3),
    .serial_in_l  (sinl3),
    .par_in       (pin3),
    .serial_out   (so3),
    .serial_out_l (sol3),
    .par_out      (pout3),
    .shift_cnt    (cnt3),
    .frame_done   (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       sin;
    logic       sinl;
    logic [7:0] pin;
    logic [7:0] expPar;
    logic [2:0] expCnt;
    logic       expDone;
    logic       rstAfter;
  } vec_t;

  typedef struct {
    logic        wide;
    logic [11:0] par;
    logic [2:0]  cnt;
    logic        done;
    logic [3:0]  so;
    logic [3:0]  sol;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];
  int   numCompared   = 0;
  int   numMismatched = 0;
  int   stepIdx       = 0;

  task automatic addVec(input logic en, input logic [1:0] mode, input logic sin,
                        input logic sinl, input logic [7:0] pin, input logic [7:0] ep,
                        input logic [2:0] ec, input logic ed, input logic rst);
    vec_t v;
    v.en = en; v.mode = mode; v.sin = sin; v.sinl = sinl; v.pin = pin;
    v.expPar = ep; v.expCnt = ec; v.expDone = ed; v.rstAfter = rst;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    numCompared++;
    if (act !== req) begin
      numMismatched++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h, required 0x%0h", name, stepIdx, act, req);
    end
  endtask

  task automatic push8(input logic [7:0] par, input logic [2:0] cnt, input logic done);
    exp_t e;
    e.wide = 1'b0; e.par = {4'h0, par}; e.cnt = cnt; e.done = done;
    e.so = {3'b000, par[7]}; e.sol = {3'b000, par[0]};
    sbQ.push_back(e);
  endtask

  task automatic push3(input logic [11:0] par, input logic [2:0] cnt, input logic done);
    exp_t e;
    e.wide = 1'b1; e.par = par; e.cnt = cnt; e.done = done;
    e.so = par[11:8]; e.sol = par[3:0];
    sbQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the matching instance.
  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      numCompared++;
      numMismatched++;
      $display("[TB] FAIL scoreboard_empty (step %0d): got 0, required 1 entry", stepIdx);
      return;
    end
    e = sbQ.pop_front();
    if (!e.wide) begin
      compare("par_out8",      {24'h0, pout8},       {20'h0, e.par});
      compare("shift_cnt8",    {29'h0, cnt8},        {29'h0, e.cnt});
      compare("frame_done8",   {31'h0, done8},       {31'h0, e.done});
      compare("serial_out8",   {31'h0, so8},         {28'h0, e.so});
      compare("serial_out_l8", {31'h0, sol8},        {28'h0, e.sol});
    end else begin
      compare("par_out3",      {20'h0, pout3},       {20'h0, e.par});
      compare("shift_cnt3",    {30'h0, cnt3},        {29'h0, e.cnt});
      compare("frame_done3",   {31'h0, done3},       {31'h0, e.done});
      compare("serial_out3",   {28'h0, so3},         {28'h0, e.so});
      compare("serial_out_l3", {28'h0, sol3},        {28'h0, e.sol});
    end
  endtask

  // Drive one operation on the 8-stage instance, then check after the edge;
  // optionally pulse reset between edges and check the immediate clear.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    en8 = v.en; mode8 = v.mode; sin8 = v.sin; sinl8 = v.sinl; pin8 = v.pin;
    push8(v.expPar, v.expCnt, v.expDone);
    @(posedge clk);
    #1;
    checkOutput();
    if (v.rstAfter) begin
      en8 = 1'b0;
      #1 reset = 1'b1;
      #1;
      push8(8'h00, 3'd0, 1'b0);
      push3(12'h000, 3'd0, 1'b0);
      checkOutput();
      checkOutput();
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic applyWide(input logic [3:0] sin, input logic [11:0] ep,
                           input logic [2:0] ec, input logic ed);
    @(negedge clk);
    en3 = 1'b1; mode3 = 2'b01; sin3 = sin;
    push3(ep, ec, ed);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    en8 = 1'b0; mode8 = 2'b00; sin8 = 1'b0; sinl8 = 1'b0; pin8 = 8'h00;
    en3 = 1'b0; mode3 = 2'b00; sin3 = 4'h0; sinl3 = 4'h0; pin3 = 12'h000;

    // Load, then asynchronous reset between edges.
    addVec(1, 2'b11, 0, 0, 8'hFF, 8'hFF, 3'd0, 0, 1);
    // SIPO: 1,0,1,1,0,1,0,1 with the first bit ending in stage 7.
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h01, 3'd1, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h02, 3'd2, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h05, 3'd3, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h0B, 3'd4, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h16, 3'd5, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h2D, 3'd6, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h5A, 3'd7, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'hB5, 3'd0, 1, 0);
    // Keep shifting zeros: serial_out replays the frame, next pulse 8 later.
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h6A, 3'd1, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'hD4, 3'd2, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'hA8, 3'd3, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h50, 3'd4, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'hA0, 3'd5, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h40, 3'd6, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h80, 3'd7, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 1, 0);
    // PISO: load 0xA5 then shift zeros.
    addVec(1, 2'b11, 0, 0, 8'hA5, 8'hA5, 3'd0, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h4A, 3'd1, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h94, 3'd2, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h28, 3'd3, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h50, 3'd4, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'hA0, 3'd5, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h40, 3'd6, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h80, 3'd7, 0, 0);
    addVec(1, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 1, 0);
    // Partial frame then reset mid-frame; counting restarts at 0.
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h01, 3'd1, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h03, 3'd2, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h07, 3'd3, 0, 1);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h01, 3'd1, 0, 0);
    // Left shift from 0x81 with serial_in_l=1.
    addVec(1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0, 0);
    addVec(1, 2'b10, 0, 1, 8'h00, 8'hC0, 3'd1, 0, 0);
    // Hold / restart: 5 shifts, en=0 for 3 cycles, mode hold, then load.
    addVec(1, 2'b11, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h01, 3'd1, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h03, 3'd2, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h07, 3'd3, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h0F, 3'd4, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h1F, 3'd5, 0, 0);
    addVec(0, 2'b01, 1, 1, 8'hAA, 8'h1F, 3'd5, 0, 0);
    addVec(0, 2'b10, 1, 1, 8'hAA, 8'h1F, 3'd5, 0, 0);
    addVec(0, 2'b11, 1, 1, 8'hAA, 8'h1F, 3'd5, 0, 0);
    addVec(1, 2'b00, 1, 1, 8'hAA, 8'h1F, 3'd5, 0, 0);
    addVec(1, 2'b11, 0, 0, 8'h3C, 8'h3C, 3'd0, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h79, 3'd1, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'hF3, 3'd2, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'hE7, 3'd3, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'hCF, 3'd4, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h9F, 3'd5, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h3F, 3'd6, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'h7F, 3'd7, 0, 0);
    addVec(1, 2'b01, 1, 0, 8'h00, 8'hFF, 3'd0, 1, 0);
    // Seven left shifts, then a load on the wrap edge suppresses the pulse.
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h7F, 3'd1, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h3F, 3'd2, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h1F, 3'd3, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h0F, 3'd4, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h07, 3'd5, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h03, 3'd6, 0, 0);
    addVec(1, 2'b10, 0, 0, 8'h00, 8'h01, 3'd7, 0, 0);
    addVec(1, 2'b11, 0, 0, 8'h55, 8'h55, 3'd0, 0, 0);
    // Mixed directions share the counter.
    addVec(1, 2'b01, 0, 0, 8'h00, 8'hAA, 3'd1, 0, 0);
    addVec(1, 2'b10, 0, 1, 8'h00, 8'hD5, 3'd2, 0, 0);

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    push8(8'h00, 3'd0, 1'b0);
    push3(12'h000, 3'd0, 1'b0);
    checkOutput();
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stepIdx = i;
      applyStimulus(vecs[i]);
    end

    // Wide lanes: 0x1, 0x2, 0x3 shifted right into a 3-stage register.
    en8 = 1'b0;
    stepIdx = 1000;
    applyWide(4'h1, 12'h001, 3'd1, 1'b0);
    applyWide(4'h2, 12'h012, 3'd2, 1'b0);
    applyWide(4'h3, 12'h123, 3'd0, 1'b1);
    applyWide(4'h0, 12'h230, 3'd1, 1'b0);

    compare("scoreboard_drain", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
